pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enables and flush/bubble

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze, taken branch,
// load-use bubble and jump flush, plus saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_id_jump,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_reg_write,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_branch_tk,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_we,
    output logic             o_if_id_we,
    output logic             o_if_id_flush,
    output logic             o_id_ex_we,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_we,
    output logic             o_mem_wb_bubble,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [1:0]       o_state
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic [1:0]        w_next_state;
    logic [WAIT_W-1:0] w_next_wait;
    logic              w_load_use;
    logic              w_freeze;

    assign w_load_use = i_ex_mem_read && i_ex_reg_write && (i_ex_rd != 5'd0) &&
                        ((i_id_use_rs && (i_id_rs == i_ex_rd)) ||
                         (i_id_use_rt && (i_id_rt == i_ex_rd)));

    // HALT and an outstanding memory access both hold the whole pipeline.
    assign w_freeze = (r_state == ST_HALT) ||
                      ((r_state == ST_WAIT) && !i_mem_ready) ||
                      ((r_state == ST_RUN) && i_mem_req && !i_mem_ready);

    always_comb begin
        o_pc_we         = 1'b1;
        o_if_id_we      = 1'b1;
        o_if_id_flush   = 1'b0;
        o_id_ex_we      = 1'b1;
        o_id_ex_flush   = 1'b0;
        o_ex_mem_we     = 1'b1;
        o_mem_wb_bubble = 1'b0;
        if (i_reset) begin
            o_pc_we     = 1'b0;
            o_if_id_we  = 1'b0;
            o_id_ex_we  = 1'b0;
            o_ex_mem_we = 1'b0;
        end else if (w_freeze) begin
            o_pc_we         = 1'b0;
            o_if_id_we      = 1'b0;
            o_id_ex_we      = 1'b0;
            o_ex_mem_we     = 1'b0;
            o_mem_wb_bubble = 1'b1;
        end else if (i_ex_branch_tk) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            o_pc_we       = 1'b0;
            o_if_id_we    = 1'b0;
            o_id_ex_flush = 1'b1;
        end else if (i_id_jump) begin
            o_if_id_flush = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (i_mem_req && !i_mem_ready) begin
                    w_next_state = ST_WAIT;
                    w_next_wait  = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (i_mem_ready) begin
                    w_next_state = ST_RUN;
                    w_next_wait  = '0;
                end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_wait = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_next_state = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
            // HALT cycles are not counted as stalls.
            if (!o_pc_we && (r_state != ST_HALT) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (o_if_id_flush && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_halted    = !i_reset && (r_state == ST_HALT);
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written multi-cycle sequences and
// randomized traffic against a rule-level reference model; second instance has CNT_W=4.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 16;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       jump;
        logic       ld;
        logic       rw;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [6:0] exp;
    } vec_t;

    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble}
    localparam logic [6:0] C_DEF = 7'b1101010;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_J   = 7'b1111010;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_RST = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, id_jump, ex_mem_read, ex_reg_write;
    logic       ex_branch_tk, mem_req, mem_ready;

    logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  state;
    logic        pc_we4, if_id_we4, if_id_flush4, id_ex_we4, id_ex_flush4, ex_mem_we4, mem_wb_bubble4, halted4;
    logic [3:0]  stall_cnt4, flush_cnt4;
    logic [1:0]  state4;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_jump(id_jump),
        .i_ex_mem_read(ex_mem_read), .i_ex_reg_write(ex_reg_write), .i_ex_rd(ex_rd),
        .i_ex_branch_tk(ex_branch_tk), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_pc_we(pc_we), .o_if_id_we(if_id_we), .o_if_id_flush(if_id_flush),
        .o_id_ex_we(id_ex_we), .o_id_ex_flush(id_ex_flush), .o_ex_mem_we(ex_mem_we),
        .o_mem_wb_bubble(mem_wb_bubble), .o_halted(halted),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_state(state)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_jump(id_jump),
        .i_ex_mem_read(ex_mem_read), .i_ex_reg_write(ex_reg_write), .i_ex_rd(ex_rd),
        .i_ex_branch_tk(ex_branch_tk), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_pc_we(pc_we4), .o_if_id_we(if_id_we4), .o_if_id_flush(if_id_flush4),
        .o_id_ex_we(id_ex_we4), .o_id_ex_flush(id_ex_flush4), .o_ex_mem_we(ex_mem_we4),
        .o_mem_wb_bubble(mem_wb_bubble4), .o_halted(halted4),
        .o_stall_cnt(stall_cnt4), .o_flush_cnt(flush_cnt4), .o_state(state4)
    );

    wire [6:0] ctrl  = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble};
    wire [6:0] ctrl4 = {pc_we4, if_id_we4, if_id_flush4, id_ex_we4, id_ex_flush4, ex_mem_we4, mem_wb_bubble4};

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [6:0] exp_q[$];

    // Reference model: consecutive memory-frozen cycles, halt flag, raw event counts.
    int m_miss  = 0;
    bit m_halt  = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic stim_t mk(int rs, int rt, bit urs, bit urt, bit j, bit ld, bit rw,
                                 int rd, bit br, bit req, bit rdy);
        stim_t s;
        s.rs = 5'(rs); s.rt = 5'(rt); s.use_rs = urs; s.use_rt = urt; s.jump = j;
        s.ld = ld; s.rw = rw; s.rd = 5'(rd); s.br = br; s.req = req; s.rdy = rdy;
        return s;
    endfunction

    function automatic int sat(int n, int w);
        int mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic bit mem_frozen(stim_t s);
        if (m_halt) return 1'b1;
        if (m_miss > 0) return !s.rdy;
        return s.req && !s.rdy;
    endfunction

    function automatic logic [6:0] model_ctrl(stim_t s);
        if (mem_frozen(s)) return C_FRZ;
        if (s.br) return C_BR;
        if (s.ld && s.rw && s.rd != 0 &&
            ((s.use_rs && s.rs == s.rd) || (s.use_rt && s.rt == s.rd))) return C_LU;
        if (s.jump) return C_J;
        return C_DEF;
    endfunction

    task automatic model_step(input stim_t s, input logic [6:0] c);
        if (!m_halt && !c[6]) m_stall++;
        if (c[4]) m_flush++;
        if (!m_halt) begin
            if (mem_frozen(s)) begin
                m_miss++;
                if (m_miss == TMO) m_halt = 1'b1;
            end else begin
                m_miss = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_miss = 0; m_halt = 0; m_stall = 0; m_flush = 0;
        exp_q.delete();
    endtask

    task automatic drive(input stim_t s);
        id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
        id_jump = s.jump; ex_mem_read = s.ld; ex_reg_write = s.rw; ex_rd = s.rd;
        ex_branch_tk = s.br; mem_req = s.req; mem_ready = s.rdy;
    endtask

    // One clock: drive after the edge, compare mid-cycle, then advance the model.
    task automatic cyc(input stim_t s, input string name);
        logic [6:0] e;
        @(posedge clk); #1;
        drive(s);
        exp_q.push_back(model_ctrl(s));
        @(negedge clk);
        e = exp_q.pop_front();
        check({name, " ctrl"}, 32'(ctrl), 32'(e));
        check({name, " ctrl4"}, 32'(ctrl4), 32'(e));
        check({name, " halted"}, 32'(halted), 32'(m_halt));
        check({name, " stall"}, 32'(stall_cnt), 32'(sat(m_stall, 16)));
        check({name, " stall4"}, 32'(stall_cnt4), 32'(sat(m_stall, 4)));
        check({name, " flush"}, 32'(flush_cnt), 32'(sat(m_flush, 16)));
        check({name, " flush4"}, 32'(flush_cnt4), 32'(sat(m_flush, 4)));
        model_step(s, e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        @(negedge clk);
        check("reset ctrl", 32'(ctrl), 32'(C_RST));
        check("reset halted", 32'(halted), 32'd0);
        check("reset counts", {stall_cnt, flush_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    vec_t vecs[9];
    stim_t idle, s;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[0] = '{"load_use_rs",   mk(5, 0, 1, 0, 0, 1, 1, 5, 0, 0, 0), C_LU};
        vecs[1] = '{"lu_rd_zero",    mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0), C_DEF};
        vecs[2] = '{"br_lu_jump",    mk(5, 0, 1, 0, 1, 1, 1, 5, 1, 0, 0), C_BR};
        vecs[3] = '{"load_use_rt",   mk(0, 7, 0, 1, 0, 1, 1, 7, 0, 0, 0), C_LU};
        vecs[4] = '{"lu_masks_jump", mk(3, 0, 1, 0, 1, 1, 1, 3, 0, 0, 0), C_LU};
        vecs[5] = '{"jump",          mk(3, 0, 1, 0, 1, 0, 1, 3, 0, 0, 0), C_J};
        vecs[6] = '{"no_use",        mk(5, 5, 0, 0, 0, 1, 1, 5, 0, 0, 0), C_DEF};
        vecs[7] = '{"mem_hit_jump",  mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1), C_J};
        vecs[8] = '{"load_no_write", mk(5, 0, 1, 0, 0, 1, 0, 5, 0, 0, 0), C_DEF};

        drive(idle);
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].s, vecs[i].name);
            check({vecs[i].name, " table"}, 32'(ctrl), 32'(vecs[i].exp));
        end
        cyc(idle, "after_table");
        check("table stall total", 32'(stall_cnt), 32'd3);
        check("table flush total", 32'(flush_cnt), 32'd3);

        // Three memory-wait cycles, release on the fourth.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mem_wait");
            check("mem_wait frozen", 32'(ctrl), 32'(C_FRZ));
        end
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "mem_release");
        check("mem_release ctrl", 32'(ctrl), 32'(C_DEF));
        cyc(idle, "after_release");
        check("mem_wait stall total", 32'(stall_cnt), 32'd3);

        // Timeout: 16 unready cycles, HALT from the 17th, sticky until reset.
        do_reset();
        for (int i = 0; i < TMO; i++) cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "timeout_wait");
        cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1), "halt17");
        check("halt17 halted", 32'(halted), 32'd1);
        check("halt17 ctrl", 32'(ctrl), 32'(C_FRZ));
        repeat (3) cyc(idle, "halt_sticky");
        do_reset();
        cyc(idle, "post_halt_run");
        check("post_halt ctrl", 32'(ctrl), 32'(C_DEF));

        // Asynchronous reset in the middle of a memory wait.
        do_reset();
        repeat (2) cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "pre_abort");
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort ctrl", 32'(ctrl), 32'(C_RST));
        check("abort counts", {stall_cnt, flush_cnt}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(idle);
        cyc(idle, "abort_run");
        check("abort_run ctrl", 32'(ctrl), 32'(C_DEF));

        // Twenty load-use stalls: the 4-bit counter holds at 15.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(vecs[0].s, "sat_stall");
        cyc(idle, "sat_done");
        check("sat stall4", 32'(stall_cnt4), 32'd15);
        check("sat stall16", 32'(stall_cnt), 32'd20);

        // Randomized traffic on a small register range to provoke hazards.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            s = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 5) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0);
            cyc(s, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
